// File: rtl/keypad_lock_ctrl.sv
// Keypad combination-lock sequencer: collects a 4-digit entry, checks it against the stored
// code and sequences the unlocking, open, error and lockout phases on the 250 Hz tick.
module keypad_lock_ctrl #(
   parameter logic [15:0] DEFAULT_CODE = 16'h1234,
   parameter int unsigned UNLOCK_CYC   = 250,
   parameter int unsigned OPEN_CYC     = 1250,
   parameter int unsigned ERR_CYC      = 250,
   parameter int unsigned MAX_FAIL     = 3,
   parameter int unsigned LOCKOUT_CYC  = 7500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   input  logic [3:0]  key,
   output logic [15:0] code_disp,
   output logic [2:0]  digit_cnt,
   output logic        unlocking,
   output logic        open,
   output logic        error,
   output logic        locked_out
);

   localparam int unsigned MaxA   = (UNLOCK_CYC > OPEN_CYC) ? UNLOCK_CYC : OPEN_CYC;
   localparam int unsigned MaxB   = (ERR_CYC > LOCKOUT_CYC) ? ERR_CYC : LOCKOUT_CYC;
   localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
   localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
   localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);

   localparam logic [TimerW-1:0] UnlockLd  = TimerW'(UNLOCK_CYC - 1);
   localparam logic [TimerW-1:0] OpenLd    = TimerW'(OPEN_CYC - 1);
   localparam logic [TimerW-1:0] ErrLd     = TimerW'(ERR_CYC - 1);
   localparam logic [TimerW-1:0] LockoutLd = TimerW'(LOCKOUT_CYC - 1);

   localparam logic [3:0] KeyA   = 4'hA;
   localparam logic [3:0] KeyClr = 4'hE;
   localparam logic [3:0] KeyEnt = 4'hF;

   typedef enum logic [2:0] {
      StEntry,
      StCheck,
      StUnlocking,
      StOpen,
      StSet,
      StError,
      StLockout
   } state_e;

   state_e              state_q, state_d;
   logic                key_valid_q;
   logic [3:0]          key_q;
   logic [15:0]         code_q, code_d, code_edit;
   logic [2:0]          cnt_q, cnt_d, cnt_edit;
   logic [FailW-1:0]    fail_q, fail_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [15:0]         stored_q, stored_d;

   logic key_dig, key_clr, key_ent, key_a;
   logic timer_zero, code_match, fail_last;

   // Key events are registered first, so a press acts on the edge after it is sampled.
   assign key_dig    = key_valid_q && (key_q <= 4'd9);
   assign key_clr    = key_valid_q && (key_q == KeyClr);
   assign key_ent    = key_valid_q && (key_q == KeyEnt);
   assign key_a      = key_valid_q && (key_q == KeyA);
   assign timer_zero = (timer_q == '0);
   assign code_match = (cnt_q == 3'd4) && (code_q == stored_q);
   assign fail_last  = (32'(fail_q) + 32'd1) >= MAX_FAIL;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StEntry;
         key_valid_q <= 1'b0;
         key_q       <= 4'd0;
         code_q      <= '0;
         cnt_q       <= '0;
         fail_q      <= '0;
         timer_q     <= '0;
         stored_q    <= DEFAULT_CODE;
      end else begin
         state_q     <= state_d;
         key_valid_q <= key_valid;
         key_q       <= key;
         code_q      <= code_d;
         cnt_q       <= cnt_d;
         fail_q      <= fail_d;
         timer_q     <= timer_d;
         stored_q    <= stored_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      cnt_d     = cnt_q;
      fail_d    = fail_q;
      stored_d  = stored_q;
      timer_d   = timer_zero ? timer_q : timer_q - TimerW'(1);
      code_edit = code_q;
      cnt_edit  = cnt_q;
      if (key_clr) begin
         code_edit = '0;
         cnt_edit  = '0;
      end else if (key_dig && (cnt_q < 3'd4)) begin
         code_edit = {code_q[11:0], key_q};
         cnt_edit  = cnt_q + 3'd1;
      end

      unique case (state_q)
         StEntry: begin
            if (key_ent) begin
               state_d = StCheck;
            end else begin
               code_d = code_edit;
               cnt_d  = cnt_edit;
            end
         end
         StCheck: begin
            code_d = '0;
            cnt_d  = '0;
            if (code_match) begin
               state_d = StUnlocking;
               fail_d  = '0;
               timer_d = UnlockLd;
            end else if (fail_last) begin
               state_d = StLockout;
               fail_d  = FailW'(MAX_FAIL);
               timer_d = LockoutLd;
            end else begin
               state_d = StError;
               fail_d  = fail_q + FailW'(1);
               timer_d = ErrLd;
            end
         end
         StUnlocking: begin
            if (timer_zero) begin
               state_d = StOpen;
               timer_d = OpenLd;
            end
         end
         StOpen: begin
            // Expiry outranks any key on the same edge.
            if (timer_zero || key_ent) begin
               state_d = StEntry;
            end else if (key_a) begin
               state_d = StSet;
               code_d  = '0;
               cnt_d   = '0;
               timer_d = OpenLd;
            end
         end
         StSet: begin
            if (timer_zero || key_ent) begin
               state_d = StEntry;
               code_d  = '0;
               cnt_d   = '0;
               if (!timer_zero && (cnt_q == 3'd4)) begin
                  stored_d = code_q;
               end
            end else begin
               code_d = code_edit;
               cnt_d  = cnt_edit;
            end
         end
         StError: begin
            if (timer_zero) begin
               state_d = StEntry;
            end
         end
         StLockout: begin
            if (timer_zero) begin
               state_d = StEntry;
               fail_d  = '0;
            end
         end
         default: begin
            state_d = StEntry;
         end
      endcase
   end

   always_comb begin
      code_disp  = code_q;
      digit_cnt  = cnt_q;
      unlocking  = (state_q == StUnlocking);
      open       = (state_q == StOpen) || (state_q == StSet);
      error      = (state_q == StError) || (state_q == StLockout);
      locked_out = (state_q == StLockout);
   end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Scoreboard bench for keypad_lock_ctrl: a phase-level model predicts every output change and
// the cycle it happens on; a monitor pops and compares each change the DUT shows.
module tb_keypad_lock_ctrl;

   localparam logic [15:0] DefCode = 16'h1234;
   localparam int unsigned UCyc    = 5;
   localparam int unsigned OCyc    = 12;
   localparam int unsigned ECyc    = 4;
   localparam int unsigned MaxFail = 3;
   localparam int unsigned LCyc    = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key = 4'd0;
   logic [15:0] code_disp;
   logic [2:0]  digit_cnt;
   logic        unlocking, open, error, locked_out;

   keypad_lock_ctrl #(
      .DEFAULT_CODE (DefCode),
      .UNLOCK_CYC   (UCyc),
      .OPEN_CYC     (OCyc),
      .ERR_CYC      (ECyc),
      .MAX_FAIL     (MaxFail),
      .LOCKOUT_CYC  (LCyc)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key        (key),
      .code_disp  (code_disp),
      .digit_cnt  (digit_cnt),
      .unlocking  (unlocking),
      .open       (open),
      .error      (error),
      .locked_out (locked_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {MEntry, MCheck, MUnlock, MOpen, MSet, MErr, MLock} mode_t;
   typedef struct {
      int          cyc;
      logic [22:0] val;
   } exp_t;

   exp_t        sb[$];
   mode_t       m_mode = MEntry;
   int          m_end = 0;
   int          m_digits[$];
   logic [15:0] m_stored = DefCode;
   int          m_fails = 0;
   logic [22:0] m_last = '0;
   int          total = 0;
   int          bad = 0;
   bit          mon_on = 1'b0;

   function automatic logic [15:0] m_code();
      int c = 0;
      foreach (m_digits[i]) c = c * 16 + m_digits[i];
      return c[15:0];
   endfunction

   function automatic logic [22:0] m_view();
      return {m_code(), 3'(m_digits.size()), m_mode == MUnlock,
              (m_mode == MOpen) || (m_mode == MSet), (m_mode == MErr) || (m_mode == MLock),
              m_mode == MLock};
   endfunction

   task automatic note(input int c);
      logic [22:0] v = m_view();
      if (v !== m_last) begin
         sb.push_back('{cyc: c, val: v});
         m_last = v;
      end
   endtask

   task automatic m_advance(input int e);
      int t;
      while (m_mode != MEntry && m_end <= e) begin
         t = m_end;
         case (m_mode)
            MCheck: begin
               if (m_digits.size() == 4 && m_code() == m_stored) begin
                  m_fails = 0;
                  m_mode  = MUnlock;
                  m_end   = t + int'(UCyc);
               end else begin
                  m_fails++;
                  if (m_fails >= int'(MaxFail)) begin
                     m_mode = MLock;
                     m_end  = t + int'(LCyc);
                  end else begin
                     m_mode = MErr;
                     m_end  = t + int'(ECyc);
                  end
               end
               m_digits.delete();
            end
            MUnlock: begin
               m_mode = MOpen;
               m_end  = t + int'(OCyc);
            end
            MSet: begin
               m_digits.delete();
               m_mode = MEntry;
            end
            MLock: begin
               m_fails = 0;
               m_mode  = MEntry;
            end
            default: m_mode = MEntry;
         endcase
         note(t);
      end
   endtask

   task automatic m_edit(input logic [3:0] k);
      if (k == 4'hE) m_digits.delete();
      else if (k <= 4'd9 && m_digits.size() < 4) m_digits.push_back(int'(k));
   endtask

   // Key that acts on edge p (one edge after the DUT samples it).
   task automatic m_key(input logic [3:0] k, input int p);
      if (m_mode inside {MCheck, MUnlock, MErr, MLock}) return;
      if (m_mode inside {MOpen, MSet} && m_end == p) return;
      case (m_mode)
         MEntry: begin
            if (k == 4'hF) begin
               m_mode = MCheck;
               m_end  = p + 1;
            end else m_edit(k);
         end
         MOpen: begin
            if (k == 4'hF) m_mode = MEntry;
            else if (k == 4'hA) begin
               m_mode = MSet;
               m_digits.delete();
               m_end = p + int'(OCyc);
            end
         end
         MSet: begin
            if (k == 4'hF) begin
               if (m_digits.size() == 4) m_stored = m_code();
               m_digits.delete();
               m_mode = MEntry;
            end else m_edit(k);
         end
         default: ;
      endcase
      note(p);
   endtask

   task automatic step();
      @(negedge clk);
      m_advance(cyc + 1);
   endtask

   task automatic gap(input int n);
      repeat (n) step();
   endtask

   task automatic press(input logic [3:0] k);
      step();
      key_valid = 1'b1;
      key       = k;
      m_key(k, cyc + 2);
      step();
      key_valid = 1'b0;
   endtask

   task automatic enter_code(input logic [15:0] c);
      for (int i = 3; i >= 0; i--) begin
         press(c[i*4 +: 4]);
         gap($urandom_range(0, 2));
      end
      press(4'hF);
   endtask

   task automatic wait_mode(input mode_t m);
      int n = 0;
      while (m_mode != m && n < 5000) begin
         step();
         n++;
      end
      if (m_mode != m) begin
         total++;
         bad++;
         $display("FAIL wait_mode timeout: mode=%0d required=%0d", m_mode, m);
      end
   endtask

   function automatic logic [15:0] rand_code();
      logic [15:0] c;
      for (int i = 0; i < 4; i++) c[i*4 +: 4] = 4'($urandom_range(0, 9));
      return c;
   endfunction

   task automatic check_idle(input string name);
      logic [22:0] cur = {code_disp, digit_cnt, unlocking, open, error, locked_out};
      total++;
      if (cur !== 23'd0) begin
         bad++;
         $display("FAIL %s: outputs=%h required=0", name, cur);
      end
   endtask

   // Reset asserted on the same edge as an 'A' press, a few cycles into OPEN.
   task automatic reset_with_key();
      step();
      rst_n     = 1'b0;
      key_valid = 1'b1;
      key       = 4'hA;
      m_mode    = MEntry;
      m_digits.delete();
      m_stored  = DefCode;
      m_fails   = 0;
      note(cyc + 1);
      step();
      rst_n     = 1'b1;
      key_valid = 1'b0;
      check_idle("reset_mid_open");
   endtask

   initial begin : monitor
      logic [22:0] prev, cur;
      exp_t        e;
      wait (mon_on);
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {code_disp, digit_cnt, unlocking, open, error, locked_out};
         if (cur !== prev) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change at cyc %0d: got=%h, none expected", cyc, cur);
            end else begin
               e = sb.pop_front();
               if (e.val !== cur || e.cyc != cyc) begin
                  bad++;
                  $display("FAIL output_change: got=%h at cyc %0d, required=%h at cyc %0d",
                           cur, cyc, e.val, e.cyc);
               end
            end
            prev = cur;
         end
      end
   end

   initial begin : stim
      int act;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("reset_state");
      mon_on = 1'b1;

      enter_code(16'h1234);
      wait_mode(MEntry);
      gap(3);
      enter_code(16'h1235);
      wait_mode(MEntry);
      enter_code(16'h1234);
      wait_mode(MEntry);

      enter_code(16'h1111);
      wait_mode(MEntry);
      enter_code(16'h2222);
      wait_mode(MEntry);
      enter_code(16'h0000);
      gap(3);
      enter_code(16'h1234);
      wait_mode(MEntry);
      enter_code(16'h1234);
      wait_mode(MEntry);

      for (int i = 1; i <= 5; i++) press(4'(i));
      press(4'hE);
      press(4'h1);
      press(4'h2);
      press(4'hF);
      wait_mode(MEntry);

      enter_code(16'h1234);
      wait_mode(MOpen);
      press(4'hA);
      press(4'h9);
      press(4'h8);
      press(4'h7);
      press(4'h6);
      press(4'hF);
      gap(2);
      enter_code(16'h1234);
      wait_mode(MEntry);
      enter_code(16'h9876);
      wait_mode(MOpen);
      gap(3);
      reset_with_key();
      gap(2);
      enter_code(16'h1234);
      wait_mode(MEntry);

      for (int it = 0; it < 40; it++) begin
         act = $urandom_range(0, 7);
         case (act)
            0, 1: enter_code(m_stored);
            2: enter_code(rand_code());
            3: begin
               for (int j = $urandom_range(0, 5); j > 0; j--) begin
                  press(($urandom_range(0, 9) == 0) ? 4'hE : 4'($urandom_range(0, 9)));
               end
               press(4'hF);
            end
            4: press(4'($urandom_range(10, 14)));
            5: begin
               wait_mode(MEntry);
               press(4'hE);
               enter_code(m_stored);
               wait_mode(MOpen);
               press(4'hA);
               for (int j = $urandom_range(3, 4); j > 0; j--) begin
                  press(4'($urandom_range(0, 9)));
                  gap($urandom_range(0, 1));
               end
               press(4'hF);
            end
            default: press(4'($urandom_range(0, 15)));
         endcase
         gap($urandom_range(0, 30));
      end

      gap(int'(LCyc + OCyc + UCyc) + 40);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
      end
      check_idle("final_idle");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
